wb_uart_master: RTL and testbench

- UART-to-Wishbone bridge acting as the bus initiator. It drives the same Wishbone slave port that the project harness exposes, so a host on an FTDI cable can select projects and read or write project registers without the management CPU.
- It receives 8N1 command frames on a single RX pin, issues one 32-bit Wishbone read or write per frame, and returns the result on a TX pin.

---
 rtl/wb_uart_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_wb_uart_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_master.sv
// UART-to-Wishbone bridge: 8N1 command frames on rx become one 32-bit Wishbone
// read or write each, and the result is returned on tx.
module wb_uart_master #(
    parameter logic [15:0] CLK_DIV = 16'd434,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        overrun
);

    localparam logic [15:0] LP_BIT_LAST  = CLK_DIV - 16'd1;
    localparam logic [15:0] LP_HALF_LAST = (CLK_DIV >> 1) - 16'd1;
    localparam logic [15:0] LP_TO_LAST   = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS, S_RESP} state_t;

    // ---------------- receiver ----------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift, r_rx_data;
    logic        r_byte_valid, r_frame_err;
    logic        w_rx_tick, w_rx_half;

    assign w_rx_tick = (r_rx_cnt == LP_BIT_LAST);
    assign w_rx_half = (r_rx_cnt == LP_HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                end
                RX_START: r_rx_cnt <= w_rx_half ? 16'd0 : r_rx_cnt + 16'd1;
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt     <= '0;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                        r_rx_data    <= r_rx_shift;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bitn;
    logic [9:0]  r_tx_shift;
    logic        w_tx_done, w_tx_start;
    logic [7:0]  w_tx_byte;

    assign w_tx_done = (r_tx_state == TX_SEND) && (r_tx_cnt == LP_BIT_LAST) && (r_tx_bitn == 4'd9);
    assign tx        = (r_tx_state == TX_SEND) ? r_tx_shift[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        if (w_tx_start)     w_tx_next = TX_SEND;
        else if (w_tx_done) w_tx_next = TX_IDLE;
    end

    // A start on the done cycle reloads the shifter so bytes run back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_tx_shift <= '1;
        end else if (w_tx_start) begin
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
        end else if (r_tx_state == TX_SEND) begin
            if (r_tx_cnt == LP_BIT_LAST) begin
                r_tx_cnt   <= '0;
                r_tx_bitn  <= r_tx_bitn + 4'd1;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- command FSM ----------------
    state_t      r_state, w_next;
    logic        r_we, r_cyc, r_err, r_overrun;
    logic [31:0] r_adr, r_dat, r_rdata;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_to_cnt;
    logic [2:0]  r_resp_left;
    logic        w_is_cmd, w_timeout;

    assign w_is_cmd  = (r_rx_data == 8'h57) || (r_rx_data == 8'h52);
    assign w_timeout = (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_byte  = r_err ? 8'h45 : (r_we ? 8'h4B : r_rdata[31:24]);
        case (r_state)
            S_IDLE:
                if (r_byte_valid && w_is_cmd) w_next = S_GET_ADDR;
            S_GET_ADDR:
                if (r_frame_err) w_next = S_IDLE;
                else if (r_byte_valid && (r_byte_cnt == 2'd3)) w_next = r_we ? S_GET_DATA : S_BUS;
            S_GET_DATA:
                if (r_frame_err) w_next = S_IDLE;
                else if (r_byte_valid && (r_byte_cnt == 2'd3)) w_next = S_BUS;
            S_BUS:
                if (r_cyc && (wbm_ack_i || w_timeout)) w_next = S_RESP;
            S_RESP:
                if ((r_resp_left != 3'd0) && ((r_tx_state == TX_IDLE) || w_tx_done)) w_tx_start = 1'b1;
                else if ((r_resp_left == 3'd0) && w_tx_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_err       <= 1'b0;
            r_overrun   <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rdata     <= '0;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
            r_resp_left <= '0;
        end else begin
            r_overrun <= r_byte_valid && ((r_state == S_BUS) || (r_state == S_RESP));
            case (r_state)
                S_IDLE:
                    if (r_byte_valid && w_is_cmd) begin
                        r_we       <= (r_rx_data == 8'h57);
                        r_byte_cnt <= '0;
                    end
                S_GET_ADDR:
                    if (r_byte_valid && !r_frame_err) begin
                        r_adr      <= {r_adr[23:0], r_rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if ((r_byte_cnt == 2'd3) && !r_we) begin
                            r_cyc    <= 1'b1;
                            r_to_cnt <= '0;
                            r_err    <= 1'b0;
                        end
                    end
                S_GET_DATA:
                    if (r_byte_valid && !r_frame_err) begin
                        r_dat      <= {r_dat[23:0], r_rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_cyc    <= 1'b1;
                            r_to_cnt <= '0;
                            r_err    <= 1'b0;
                        end
                    end
                S_BUS:
                    if (r_cyc && wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rdata     <= wbm_dat_i;
                        r_resp_left <= r_we ? 3'd1 : 3'd4;
                    end else if (r_cyc && w_timeout) begin
                        r_cyc       <= 1'b0;
                        r_err       <= 1'b1;
                        r_resp_left <= 3'd1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                S_RESP:
                    if (w_tx_start) begin
                        r_resp_left <= r_resp_left - 3'd1;
                        r_rdata     <= {r_rdata[23:0], 8'h00};
                    end
                default: r_cyc <= 1'b0;
            endcase
        end
    end

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_cyc ? 4'hF : 4'h0;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_wb_uart_master.sv
// Randomised bench for wb_uart_master: bit-banged rx frames, a Wishbone slave
// with programmable latency, and a tx decoder compared against a frame model.
module tb_wb_uart_master;

    localparam int CD = 8;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy, overrun;

    always #5 clk = ~clk;

    wb_uart_master #(.CLK_DIV(16'd8), .TIMEOUT(16'd20)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .busy(busy), .overrun(overrun)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_case = "reset";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_case, tag, got, exp);
        end
    endtask

    // ---------------- Wishbone slave ----------------
    int          slv_delay = 0;
    bit          slv_never = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          slv_wait  = 0;

    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
            if (wbm_cyc_o && !slv_never) begin
                if (slv_wait == slv_delay) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = slv_rdata;
                    slv_wait  = 0;
                end else begin
                    slv_wait++;
                end
            end else begin
                slv_wait = 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          bus_count = 0, bus_err = 0, cur_len = 0, last_len = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we, prev_cyc = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && !prev_cyc) begin
                bus_count++;
                cur_len = 0;
                cap_adr = wbm_adr_o;
                cap_dat = wbm_dat_o;
                cap_we  = wbm_we_o;
            end
            if (wbm_cyc_o) begin
                cur_len++;
                if (wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat || wbm_we_o !== cap_we) bus_err++;
                if (wbm_sel_o !== 4'hF || wbm_stb_o !== 1'b1) bus_err++;
            end else begin
                if (wbm_sel_o !== 4'h0 || wbm_stb_o !== 1'b0) bus_err++;
                if (prev_cyc) last_len = cur_len;
            end
            prev_cyc = wbm_cyc_o;
        end
    end

    // ---------------- overrun monitor ----------------
    int   ov_pulses = 0, ov_cycles = 0;
    logic ov_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (overrun === 1'b1) ov_cycles++;
            if (overrun === 1'b1 && !ov_prev) ov_pulses++;
            ov_prev = (overrun === 1'b1);
        end
    end

    // ---------------- tx decoder: every clock of every bit must hold its value ----------------
    logic [7:0] tx_q[$];
    int         tx_bad = 0;
    logic       stop_busy = 1'b0;
    logic [9:0] mbits;
    bit         mok;

    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b0) begin
                mbits = '0;
                mok   = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < CD; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (s == 0 && b != 0) mbits[b] = tx;
                        else if (tx !== mbits[b]) mok = 1'b0;
                    end
                end
                stop_busy = busy;
                if (!mok || mbits[9] !== 1'b1) tx_bad++;
                tx_q.push_back(mbits[8:1]);
            end
        end
    end

    // ---------------- rx driver ----------------
    task automatic send_bits(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CD) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({1'b1, b, 1'b0});
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // mode: 0 plain, 1 extra byte after the frame, 2 glitch after command, 3 unknown byte before
    task automatic run_frame(input bit is_wr, input logic [31:0] adr, input logic [31:0] dat,
                             input int delay, input bit never, input logic [31:0] rd, input int mode);
        logic [7:0]  exp_q[$];
        logic [31:0] tmp;
        int          bc0, ovp0, ovc0, k;
        slv_delay = delay;
        slv_never = never;
        slv_rdata = rd;
        bc0  = bus_count;
        ovp0 = ov_pulses;
        ovc0 = ov_cycles;
        tx_q.delete();
        if (mode == 3) send_byte(8'h41);
        send_byte(is_wr ? 8'h57 : 8'h52);
        if (mode == 2) begin
            rx = 1'b0;
            @(negedge clk);
            idle(12 * CD);
        end
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
        if (is_wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
        if (mode == 1) send_byte(8'h52);
        rx = 1'b1;

        if (never)      exp_q.push_back(8'h45);
        else if (is_wr) exp_q.push_back(8'h4B);
        else begin
            tmp = rd;
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(tmp[31:24]);
                tmp = tmp << 8;
            end
        end

        k = 0;
        while (!(tx_q.size() >= exp_q.size() && busy === 1'b0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("resp_wait", (k < 4000), 1);
        check("bus_count", bus_count - bc0, 1);
        check("adr", cap_adr, adr);
        check("we", cap_we, is_wr);
        if (is_wr) check("dat_o", cap_dat, dat);
        check("cyc_len", last_len, never ? TO : delay + 1);
        check("resp_len", tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) check("resp_byte", tx_q[i], exp_q[i]);
        check("tx_framing", tx_bad, 0);
        check("bus_proto", bus_err, 0);
        check("busy_at_stop", stop_busy, 1);
        check("busy_end", busy, 0);
        check("overrun_pulses", ov_pulses - ovp0, (mode == 1) ? 1 : 0);
        check("overrun_cycles", ov_cycles - ovc0, (mode == 1) ? 1 : 0);
        idle(2 * CD);
    endtask

    initial begin
        int          k, bc0;
        logic [31:0] a, d, r;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("tx", tx, 1);
        check("cyc", wbm_cyc_o, 0);
        check("stb", wbm_stb_o, 0);
        check("we", wbm_we_o, 0);
        check("sel", wbm_sel_o, 0);
        check("adr", wbm_adr_o, 0);
        check("dat_o", wbm_dat_o, 0);
        check("busy", busy, 0);
        check("overrun", overrun, 0);
        reset = 1'b0;
        idle(4 * CD);

        cur_case = "select";
        run_frame(1'b1, 32'h3000_0000, 32'h0000_0002, 1, 1'b0, 32'h0, 0);
        cur_case = "read";
        run_frame(1'b0, 32'h3000_0418, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
        cur_case = "timeout_wr";
        run_frame(1'b1, 32'h4000_0000, 32'h1234_5678, 0, 1'b1, 32'h0, 0);
        cur_case = "timeout_rd";
        run_frame(1'b0, 32'h4000_0004, 32'h0, 0, 1'b1, 32'h0, 0);
        cur_case = "ack_at_limit";
        run_frame(1'b0, 32'h3000_0010, 32'h0, TO - 1, 1'b0, 32'hA5C3_0F96, 0);

        cur_case = "framing";
        bc0 = bus_count;
        send_byte(8'h52);
        send_byte(8'h30);
        send_bits({1'b0, 8'h00, 1'b0});
        idle(3 * CD);
        check("busy_after_ferr", busy, 0);
        check("no_bus", bus_count - bc0, 0);
        run_frame(1'b0, 32'h3000_0000, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 0);

        cur_case = "glitch";
        run_frame(1'b0, 32'h3000_0020, 32'h0, 2, 1'b0, 32'h1357_9BDF, 2);
        cur_case = "unknown_cmd";
        run_frame(1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h2468_ACE0, 3);
        cur_case = "overrun";
        run_frame(1'b0, 32'h3000_0030, 32'h0, 15, 1'b0, 32'hC001_D00D, 1);

        cur_case = "reset_mid";
        slv_never = 1'b1;
        send_byte(8'h57);
        for (int i = 0; i < 8; i++) send_byte(8'h11);
        k = 0;
        while (wbm_cyc_o !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("cyc_rise", wbm_cyc_o, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("cyc", wbm_cyc_o, 0);
        check("stb", wbm_stb_o, 0);
        check("tx", tx, 1);
        check("busy", busy, 0);
        reset = 1'b0;
        tx_q.delete();
        idle(200);
        check("no_resp", tx_q.size(), 0);
        run_frame(1'b1, 32'h3000_0040, 32'hFEED_0001, 2, 1'b0, 32'h0, 0);

        for (int n = 0; n < 10; n++) begin
            cur_case = $sformatf("rand%0d", n);
            a = $urandom;
            d = $urandom;
            r = $urandom;
            run_frame($urandom_range(0, 1) == 1, a, d, $urandom_range(0, TO - 1),
                      $urandom_range(0, 3) == 0, r, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
